// File: rtl/scoreboard_bypass_unit_pkg.sv
// Shared widths, latency limits and the per-register scoreboard entry type
// for the decode-stage scoreboard/bypass unit.
package scoreboard_bypass_unit_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_REG_WIDTH  = 5;
    localparam int unsigned DEF_NUM_REGS   = 32;
    localparam int unsigned NUM_FWD_SRC    = 4;
    localparam int unsigned MAX_LAT        = 7;
    localparam int unsigned LAT_WIDTH      = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic                 pending;
        logic [LAT_WIDTH-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/scoreboard_bypass_unit_if.sv
// Decode-side bundle of the scoreboard/bypass unit: issue request, operand
// reads, forwarding sources, writeback commit and the resulting stall/operands.
interface scoreboard_bypass_unit_if
    import scoreboard_bypass_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REGISTER_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
    parameter int unsigned NUM_SRC        = NUM_FWD_SRC
);
    localparam int unsigned INF_W = $clog2(NUM_REGS + 1);

    logic                          issue_valid_i;
    logic                          issue_wb_i;
    logic [REGISTER_WIDTH-1:0]     issue_rd_i;
    logic [LAT_WIDTH-1:0]          issue_lat_i;
    logic                          flush_i;
    logic [REGISTER_WIDTH-1:0]     rs1_i;
    logic [REGISTER_WIDTH-1:0]     rs2_i;
    logic                          rs1_needed_i;
    logic                          rs2_needed_i;
    logic [DATA_WIDTH-1:0]         rs1_data_i;
    logic [DATA_WIDTH-1:0]         rs2_data_i;
    logic [NUM_SRC-1:0]            fwd_valid_i;
    logic [NUM_SRC*REGISTER_WIDTH-1:0] fwd_reg_i;
    logic [NUM_SRC*DATA_WIDTH-1:0] fwd_data_i;
    logic                          wb_valid_i;
    logic [REGISTER_WIDTH-1:0]     wb_reg_i;
    logic                          stall_o;
    logic                          issue_fire_o;
    logic [DATA_WIDTH-1:0]         rs1_data_o;
    logic [DATA_WIDTH-1:0]         rs2_data_o;
    logic [NUM_REGS-1:0]           pending_o;
    logic [INF_W-1:0]              inflight_o;

    modport master (
        output issue_valid_i, issue_wb_i, issue_rd_i, issue_lat_i, flush_i,
        output rs1_i, rs2_i, rs1_needed_i, rs2_needed_i, rs1_data_i, rs2_data_i,
        output fwd_valid_i, fwd_reg_i, fwd_data_i, wb_valid_i, wb_reg_i,
        input  stall_o, issue_fire_o, rs1_data_o, rs2_data_o, pending_o, inflight_o
    );

    modport slave (
        input  issue_valid_i, issue_wb_i, issue_rd_i, issue_lat_i, flush_i,
        input  rs1_i, rs2_i, rs1_needed_i, rs2_needed_i, rs1_data_i, rs2_data_i,
        input  fwd_valid_i, fwd_reg_i, fwd_data_i, wb_valid_i, wb_reg_i,
        output stall_o, issue_fire_o, rs1_data_o, rs2_data_o, pending_o, inflight_o
    );

endinterface

// File: rtl/scoreboard_bypass_unit_fwd_select.sv
// Per-operand priority forwarding: lowest-index matching source wins, with a
// writeback-commit match reported separately for the scoreboard's fallback.
module scoreboard_bypass_unit_fwd_select
    import scoreboard_bypass_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REGISTER_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned NUM_SRC        = NUM_FWD_SRC
) (
    input  logic [REGISTER_WIDTH-1:0]         reg_i,
    input  logic                              needed_i,
    input  logic [DATA_WIDTH-1:0]             rf_data_i,
    input  logic [NUM_SRC-1:0]                fwd_valid_i,
    input  logic [NUM_SRC*REGISTER_WIDTH-1:0] fwd_reg_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     fwd_data_i,
    input  logic                              wb_valid_i,
    input  logic [REGISTER_WIDTH-1:0]         wb_reg_i,
    output logic                              src_hit_o,
    output logic                              wb_hit_o,
    output logic [DATA_WIDTH-1:0]             data_o
);
    logic                  live;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;

    assign live = needed_i && (reg_i != '0);

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (fwd_valid_i[i-1] && (fwd_reg_i[(i-1)*REGISTER_WIDTH +: REGISTER_WIDTH] == reg_i)) begin
                hit      = 1'b1;
                hit_data = fwd_data_i[(i-1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign src_hit_o = live && hit;
    // The register file is write-through, so a committing value is already on rf_data_i.
    assign wb_hit_o  = live && wb_valid_i && (wb_reg_i == reg_i);

    always_comb begin
        data_o = rf_data_i;
        if (reg_i == '0) begin
            data_o = '0;
        end else if (src_hit_o) begin
            data_o = hit_data;
        end
    end

endmodule

// File: rtl/scoreboard_bypass_unit.sv
// Decode-stage scoreboard of in-flight writers with latency countdowns plus
// rs1/rs2 priority forwarding; produces the decode stall and resolved operands.
module scoreboard_bypass_unit
    import scoreboard_bypass_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REGISTER_WIDTH = DEF_REG_WIDTH,
    parameter int unsigned NUM_REGS       = DEF_NUM_REGS,
    parameter int unsigned NUM_SRC        = NUM_FWD_SRC
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    scoreboard_bypass_unit_if.slave bus_if
);
    localparam int unsigned INF_W = $clog2(NUM_REGS + 1);

    sb_entry_t        sb_q [NUM_REGS];
    sb_entry_t        sb_d [NUM_REGS];
    logic [INF_W-1:0] inflight_q, inflight_d;

    sb_entry_t ent1, ent2, ent_rd, ent_wb;
    logic      src_hit1, wb_hit1, src_hit2, wb_hit2;
    logic      raw1, raw2, waw, retire, retire_rd, stall, fire, set, inc, dec;
    logic [NUM_REGS-1:0] pending;

    scoreboard_bypass_unit_fwd_select #(
        .DATA_WIDTH(DATA_WIDTH), .REGISTER_WIDTH(REGISTER_WIDTH), .NUM_SRC(NUM_SRC)
    ) u_fwd_rs1 (
        .reg_i(bus_if.rs1_i), .needed_i(bus_if.rs1_needed_i), .rf_data_i(bus_if.rs1_data_i),
        .fwd_valid_i(bus_if.fwd_valid_i), .fwd_reg_i(bus_if.fwd_reg_i), .fwd_data_i(bus_if.fwd_data_i),
        .wb_valid_i(bus_if.wb_valid_i), .wb_reg_i(bus_if.wb_reg_i),
        .src_hit_o(src_hit1), .wb_hit_o(wb_hit1), .data_o(bus_if.rs1_data_o)
    );

    scoreboard_bypass_unit_fwd_select #(
        .DATA_WIDTH(DATA_WIDTH), .REGISTER_WIDTH(REGISTER_WIDTH), .NUM_SRC(NUM_SRC)
    ) u_fwd_rs2 (
        .reg_i(bus_if.rs2_i), .needed_i(bus_if.rs2_needed_i), .rf_data_i(bus_if.rs2_data_i),
        .fwd_valid_i(bus_if.fwd_valid_i), .fwd_reg_i(bus_if.fwd_reg_i), .fwd_data_i(bus_if.fwd_data_i),
        .wb_valid_i(bus_if.wb_valid_i), .wb_reg_i(bus_if.wb_reg_i),
        .src_hit_o(src_hit2), .wb_hit_o(wb_hit2), .data_o(bus_if.rs2_data_o)
    );

    assign ent1   = sb_q[bus_if.rs1_i];
    assign ent2   = sb_q[bus_if.rs2_i];
    assign ent_rd = sb_q[bus_if.issue_rd_i];
    assign ent_wb = sb_q[bus_if.wb_reg_i];

    assign raw1 = bus_if.rs1_needed_i && (bus_if.rs1_i != '0) && ent1.pending &&
                  ((ent1.cnt != '0) || (!src_hit1 && !wb_hit1));
    assign raw2 = bus_if.rs2_needed_i && (bus_if.rs2_i != '0) && ent2.pending &&
                  ((ent2.cnt != '0) || (!src_hit2 && !wb_hit2));

    assign retire    = bus_if.wb_valid_i && (bus_if.wb_reg_i != '0) && ent_wb.pending && (ent_wb.cnt == '0);
    assign retire_rd = retire && (bus_if.wb_reg_i == bus_if.issue_rd_i);

    // An entry retiring this edge no longer blocks a new writer of the same register.
    assign waw   = bus_if.issue_wb_i && (bus_if.issue_rd_i != '0) && ent_rd.pending && !retire_rd;
    assign stall = bus_if.issue_valid_i && (raw1 || raw2 || waw);
    assign fire  = bus_if.issue_valid_i && !stall && !bus_if.flush_i;
    assign set   = fire && bus_if.issue_wb_i && (bus_if.issue_rd_i != '0);
    assign inc   = set && !ent_rd.pending;
    assign dec   = retire && !(set && retire_rd);

    always_comb begin
        sb_d = sb_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (sb_q[i].pending && (sb_q[i].cnt != '0)) begin
                sb_d[i].cnt = sb_q[i].cnt - LAT_WIDTH'(1);
            end
            if (retire && (bus_if.wb_reg_i == REGISTER_WIDTH'(i))) begin
                sb_d[i] = '0;
            end
            if (set && (bus_if.issue_rd_i == REGISTER_WIDTH'(i))) begin
                sb_d[i].pending = 1'b1;
                sb_d[i].cnt     = bus_if.issue_lat_i;
            end
        end
    end

    assign inflight_d = inflight_q + INF_W'(inc) - INF_W'(dec);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q       <= '{default: '0};
            inflight_q <= '0;
        end else begin
            sb_q       <= sb_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            pending[i] = sb_q[i].pending;
        end
    end

    assign bus_if.stall_o      = stall;
    assign bus_if.issue_fire_o = fire;
    assign bus_if.pending_o    = pending;
    assign bus_if.inflight_o   = inflight_q;

endmodule

// File: tb/tb_scoreboard_bypass_unit.sv
// Directed bench for scoreboard_bypass_unit: countdown stalls, forwarding
// priority, WAW, x0 handling, flush, issue/retire collision and async reset.
module tb_scoreboard_bypass_unit;
    import scoreboard_bypass_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    scoreboard_bypass_unit_if sif ();

    scoreboard_bypass_unit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sif.issue_valid_i = 1'b0;
        sif.issue_wb_i    = 1'b0;
        sif.issue_rd_i    = '0;
        sif.issue_lat_i   = '0;
        sif.flush_i       = 1'b0;
        sif.rs1_i         = '0;
        sif.rs2_i         = '0;
        sif.rs1_needed_i  = 1'b0;
        sif.rs2_needed_i  = 1'b0;
        sif.rs1_data_i    = '0;
        sif.rs2_data_i    = '0;
        sif.fwd_valid_i   = '0;
        sif.fwd_reg_i     = '0;
        sif.fwd_data_i    = '0;
        sif.wb_valid_i    = 1'b0;
        sif.wb_reg_i      = '0;
    endtask

    task automatic set_fwd(input int src, input logic [4:0] r, input logic [31:0] d);
        sif.fwd_valid_i[src]        = 1'b1;
        sif.fwd_reg_i[src*5 +: 5]   = r;
        sif.fwd_data_i[src*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        sif.issue_valid_i = 1'b1;
        sif.issue_wb_i    = 1'b1;
        sif.issue_rd_i    = rd;
        sif.issue_lat_i   = lat;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd4;
        sif.rs1_needed_i  = 1'b1;
        sif.rs1_data_i    = 32'h1234;
        #3;
        chk("reset_stall", sif.stall_o, 0);
        chk("reset_pending", sif.pending_o, 0);
        chk("reset_inflight", sif.inflight_o, 0);
        chk("reset_rs1_passthru", sif.rs1_data_o, 32'h1234);
        rst_n = 1'b1;
        step();
        idle();

        // rd=5, lat=3: three stall cycles, then forward from source 2
        issue(5'd5, 3'd3);
        #1;
        chk("iss5_fire", sif.issue_fire_o, 1);
        chk("iss5_stall", sif.stall_o, 0);
        step();
        idle();
        chk("iss5_pending", sif.pending_o, 32'h0000_0020);
        chk("iss5_inflight", sif.inflight_o, 1);
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd5;
        sif.rs1_needed_i  = 1'b1;
        sif.rs1_data_i    = 32'h1111;
        #1;
        chk("raw_cnt3", sif.stall_o, 1);
        step();
        chk("raw_cnt2", sif.stall_o, 1);
        step();
        chk("raw_cnt1", sif.stall_o, 1);
        step();
        chk("raw_cnt0_nosrc", sif.stall_o, 1);
        set_fwd(2, 5'd5, 32'hDEAD);
        #1;
        chk("fwd2_stall", sif.stall_o, 0);
        chk("fwd2_data", sif.rs1_data_o, 32'hDEAD);
        chk("fwd2_fire", sif.issue_fire_o, 1);
        sif.wb_valid_i = 1'b1;
        sif.wb_reg_i   = 5'd5;
        sif.rs1_data_i = 32'h5555;
        #1;
        chk("fwd_over_wb", sif.rs1_data_o, 32'hDEAD);
        step();
        idle();
        #1;
        chk("clr5_pending", sif.pending_o, 0);
        chk("clr5_inflight", sif.inflight_o, 0);

        // lat=0 with no forwarding source: writeback commit resolves the operand
        issue(5'd6, 3'd0);
        #1;
        step();
        idle();
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd6;
        sif.rs1_needed_i  = 1'b1;
        sif.wb_valid_i    = 1'b1;
        sif.wb_reg_i      = 5'd6;
        sif.rs1_data_i    = 32'hBEEF;
        #1;
        chk("wbfb_stall", sif.stall_o, 0);
        chk("wbfb_data", sif.rs1_data_o, 32'hBEEF);
        step();
        idle();
        #1;
        chk("wbfb_pending", sif.pending_o, 0);

        // two sources match rs2=7, not pending: lowest index wins
        sif.issue_valid_i = 1'b1;
        sif.rs2_i         = 5'd7;
        sif.rs2_needed_i  = 1'b1;
        sif.rs2_data_i    = 32'h99;
        set_fwd(1, 5'd7, 32'h11);
        set_fwd(3, 5'd7, 32'h33);
        #1;
        chk("prio_data", sif.rs2_data_o, 32'h11);
        chk("prio_stall", sif.stall_o, 0);
        step();
        idle();

        // WAW on rd=9, then clear by writeback and reissue
        issue(5'd9, 3'd2);
        #1;
        chk("iss9_fire", sif.issue_fire_o, 1);
        step();
        idle();
        chk("iss9_pending", sif.pending_o, 32'h0000_0200);
        chk("iss9_inflight", sif.inflight_o, 1);
        issue(5'd9, 3'd2);
        #1;
        chk("waw_stall", sif.stall_o, 1);
        chk("waw_fire", sif.issue_fire_o, 0);
        step();
        step();
        idle();
        sif.wb_valid_i = 1'b1;
        sif.wb_reg_i   = 5'd9;
        #1;
        step();
        idle();
        #1;
        chk("clr9_pending", sif.pending_o, 0);
        chk("clr9_inflight", sif.inflight_o, 0);
        issue(5'd9, 3'd2);
        #1;
        chk("reiss9_stall", sif.stall_o, 0);
        chk("reiss9_fire", sif.issue_fire_o, 1);
        step();
        idle();
        chk("reiss9_pending", sif.pending_o, 32'h0000_0200);
        chk("reiss9_inflight", sif.inflight_o, 1);

        // x0 is never tracked and never forwarded
        issue(5'd0, 3'd4);
        #1;
        chk("x0_fire", sif.issue_fire_o, 1);
        step();
        idle();
        #1;
        chk("x0_pending", sif.pending_o, 32'h0000_0200);
        chk("x0_inflight", sif.inflight_o, 1);
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd0;
        sif.rs1_needed_i  = 1'b1;
        sif.rs1_data_i    = 32'h77;
        set_fwd(0, 5'd0, 32'hFF);
        #1;
        chk("x0_data", sif.rs1_data_o, 0);
        chk("x0_stall", sif.stall_o, 0);
        step();
        idle();

        // flush suppresses the scoreboard update
        issue(5'd12, 3'd1);
        sif.flush_i = 1'b1;
        #1;
        chk("flush_fire", sif.issue_fire_o, 0);
        chk("flush_stall", sif.stall_o, 0);
        step();
        idle();
        chk("flush_pending", sif.pending_o, 32'h0000_0200);
        chk("flush_inflight", sif.inflight_o, 1);

        // issue and retire of rd=3 in the same cycle: issue wins, count nets 0
        issue(5'd3, 3'd0);
        #1;
        step();
        idle();
        chk("iss3_pending", sif.pending_o, 32'h0000_0208);
        chk("iss3_inflight", sif.inflight_o, 2);
        issue(5'd3, 3'd5);
        sif.wb_valid_i = 1'b1;
        sif.wb_reg_i   = 5'd3;
        #1;
        chk("coll_stall", sif.stall_o, 0);
        chk("coll_fire", sif.issue_fire_o, 1);
        step();
        idle();
        chk("coll_pending", sif.pending_o, 32'h0000_0208);
        chk("coll_inflight", sif.inflight_o, 2);
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd3;
        sif.rs1_needed_i  = 1'b1;
        #1;
        chk("coll_reload_stall", sif.stall_o, 1);
        idle();

        // four pending, then asynchronous reset mid-countdown
        issue(5'd20, 3'd7);
        #1;
        step();
        issue(5'd21, 3'd7);
        #1;
        step();
        idle();
        #1;
        chk("fill_inflight", sif.inflight_o, 4);
        chk("fill_pending", sif.pending_o, 32'h0030_0208);
        step();
        sif.issue_valid_i = 1'b1;
        sif.rs1_i         = 5'd20;
        sif.rs1_needed_i  = 1'b1;
        sif.rs1_data_i    = 32'hABCD;
        #1;
        chk("prerst_stall", sif.stall_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_pending", sif.pending_o, 0);
        chk("arst_inflight", sif.inflight_o, 0);
        chk("arst_stall", sif.stall_o, 0);
        chk("arst_rs1", sif.rs1_data_o, 32'hABCD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scoreboard_bypass_unit.md
Name: scoreboard_bypass_unit

Overview:
- Parametrised successor to the decode-stage operand bypass.
- Combines an N-source priority forwarding network with a per-register scoreboard of in-flight writers, each tagged with a latency countdown.
- Produces the decode stall and the forwarded rs1/rs2 operands for any mix of fixed-latency units: ALU, MEM, multi-cycle MUL/EX.
- Sits between the register file read and the issue of the decode stage.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REGISTER_WIDTH, 5, architectural register index width.
- NUM_REGS, 32, number of scoreboard entries (x0 included, never tracked).
- NUM_SRC, 4, forwarding sources; index 0 is the youngest and has the highest priority.
- MAX_LAT, 7, largest producer latency in cycles.
- LAT_WIDTH, $clog2(MAX_LAT+1), countdown width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  decode has an instruction attempting issue
- issue_wb_i  in  1  instruction writes a register
- issue_rd_i  in  REGISTER_WIDTH  destination register
- issue_lat_i  in  LAT_WIDTH  cycles until the result appears on a forwarding source
- flush_i  in  1  kill the current decode instruction (branch taken / jump)
- rs1_i, rs2_i  in  REGISTER_WIDTH each  source registers
- rs1_needed_i, rs2_needed_i  in  1 each  operand actually read
- rs1_data_i, rs2_data_i  in  DATA_WIDTH each  register file read data
- fwd_valid_i  in  NUM_SRC  source carries a register write this cycle
- fwd_reg_i  in  NUM_SRC*REGISTER_WIDTH  packed destination registers
- fwd_data_i  in  NUM_SRC*DATA_WIDTH  packed results
- wb_valid_i  in  1  register file write commits this cycle
- wb_reg_i  in  REGISTER_WIDTH  committed register
- stall_o  out  1  decode must hold
- issue_fire_o  out  1  issue accepted (issue_valid_i & ~stall_o & ~flush_i)
- rs1_data_o, rs2_data_o  out  DATA_WIDTH each  resolved operands
- pending_o  out  NUM_REGS  scoreboard pending bits (bit 0 always 0)
- inflight_o  out  $clog2(NUM_REGS+1)  count of pending registers

Behaviour:

Scoreboard state and reset:
- Per-register state is pending bit + cnt[LAT_WIDTH].
- rst_ni low asynchronously clears all pending, cnt and inflight.
- After reset: stall_o=0, pending_o=0, inflight_o=0, operands equal the regfile inputs.
- Reset mid-operation discards all in-flight tracking; there is no recovery.

Counting and issue:
- Each cycle, every pending entry with cnt>0 decrements by 1 and saturates at 0.
- On issue_fire_o & issue_wb_i & issue_rd_i!=0: entry rd gets pending=1, cnt=issue_lat_i, registered at the next edge.
- issue_lat_i=0 means the result is forwardable the next cycle.
- Entry clears at the edge where wb_valid_i & wb_reg_i matches & cnt==0.
- Simultaneous issue and clear of the same rd: issue wins (pending stays 1, cnt reloads).

Operand hazard (per operand, operand needed and reg!=0):
- pending & cnt!=0 -> RAW stall.
- pending & cnt==0 -> take the lowest-index fwd source with fwd_valid & reg match.
- If pending & cnt==0 and no source matches -> take wb_data only if wb_valid_i & wb_reg_i match; otherwise stall.
- Not pending -> lowest-index matching fwd source if any (covers untracked late writes), else rs*_data_i.

Other stall and operand rules:
- WAW: issue_wb_i with issue_rd_i already pending -> stall.
- stall_o = issue_valid_i & (RAW1 | RAW2 | WAW). It is combinational from state and inputs.
- flush_i: issue ignored, no scoreboard update, stall_o still computed. In-flight entries are untouched because older instructions still commit.
- Register 0 is never pending, never forwarded, and its operand is always 0.
- inflight_o is updated every cycle: +1 on set of a non-pending entry, -1 on clear, net 0 when both occur.

Decomposition:
- Add to params_pkg: MAX_LAT, LAT_WIDTH, NUM_FWD_SRC, and typedef sb_entry_t {pending, cnt}.
- One natural sub-module: fwd_select, instantiated twice (rs1/rs2). It takes a register index and needed flag and returns hit + data, doing the priority encode over NUM_SRC plus the wb fallback.
- The scoreboard register array and counters stay in the top module.

Test Plan:
- Reset then issue rd=5, lat=3; next cycle read rs1=5 needed -> stall_o=1 for 3 cycles. Then fwd_valid[2]=1, reg=5, data=0xDEAD -> stall_o=0, rs1_data_o=0xDEAD.
- Two sources match rs2=7 (src1 data=0x11, src3 data=0x33), not pending -> rs2_data_o=0x11.
- Issue rd=9 lat=2 while 9 pending -> stall_o=1, issue_fire_o=0. After wb_valid_i reg=9 with cnt=0 -> pending_o[9] clears, reissue accepted, inflight_o unchanged net.
- Issue rd=0 lat=4, then read rs1=0 with fwd_valid reg=0 data=0xFF -> pending_o=0, rs1_data_o=0, no stall.
- flush_i=1 with issue rd=12 -> pending_o[12] stays 0. Issue and wb clear of rd=3 same cycle -> pending_o[3]=1, cnt reloaded.
- Fill 4 pending regs, assert rst_ni=0 mid-countdown -> pending_o=0, inflight_o=0, stall_o=0 immediately.
